// File: rtl/synth_sample_pkg.sv
// Shared types for the synth sample path: window magnitude type and collector states.
package synth_sample_pkg;

  localparam int SAMPLE_OUT_W = 32;
  localparam int SWC_WIN_LEN  = 4;

  typedef enum logic {SWC_FILL, SWC_FULL} swc_state_t;

  typedef logic [SAMPLE_OUT_W-1:0] mag_t;

endpackage

// File: rtl/sample_magnitude.sv
// Combinational |x| of a signed sample, zero-extended to mag_t.
// The most-negative input maps to 2^(IN_W-1) because the negate is done one bit wider.
module sample_magnitude
  import synth_sample_pkg::*;
#(
  parameter int IN_W = 24
) (
  input  logic signed [IN_W-1:0] sample_i,
  output mag_t                   mag_o
);

  logic [IN_W:0] ext;
  logic [IN_W:0] abs_val;

  always_comb begin
    ext     = {sample_i[IN_W-1], sample_i};
    abs_val = sample_i[IN_W-1] ? -ext : ext;
    mag_o   = '0;
    mag_o[IN_W:0] = abs_val;
  end

endmodule

// File: rtl/sample_window_collector.sv
// Collects signed samples into a 4-slot window of magnitudes, emitting one window every HOP accepts.
// Optional macro SWC_WINDOW_COUNT_EN adds a 16-bit emitted-window counter output.
module sample_window_collector
  import synth_sample_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32,
  parameter int HOP   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic signed [IN_W-1:0] in_sample,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       sample0,
  output logic [OUT_W-1:0]       sample1,
  output logic [OUT_W-1:0]       sample2,
  output logic [OUT_W-1:0]       sample3,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef SWC_WINDOW_COUNT_EN
  output logic [15:0]            window_count,
`endif
  output swc_state_t             dbg_state
);

  if (OUT_W != SAMPLE_OUT_W) begin : g_bad_out_w
    $error("sample_window_collector: OUT_W must be %0d", SAMPLE_OUT_W);
  end
  if (IN_W < 8 || IN_W >= OUT_W) begin : g_bad_in_w
    $error("sample_window_collector: IN_W out of range");
  end
  if (HOP < 1 || HOP > 4) begin : g_bad_hop
    $error("sample_window_collector: HOP out of range");
  end

  localparam logic [2:0] HOP_C  = 3'(HOP);
  localparam logic [2:0] FULL_C = 3'(SWC_WIN_LEN);

  swc_state_t state_q, state_d;
  mag_t       w_q [SWC_WIN_LEN];
  mag_t       w_d [SWC_WIN_LEN];
  logic [2:0] fill_cnt_q, fill_cnt_d;
  logic [2:0] hop_cnt_q, hop_cnt_d;
  logic       first_q, first_d;

  mag_t       mag;
  logic [2:0] fill_inc;
  logic [2:0] hop_inc;
  logic       accept;
  logic       emit;

  sample_magnitude #(.IN_W(IN_W)) u_mag (
    .sample_i (in_sample),
    .mag_o    (mag)
  );

  // Handshakes: a sample transfers on a clk edge where in_valid && in_ready (and no flush);
  // a window transfers on an edge where out_valid && out_ready. Both ready/valid are
  // registered state, so there is no combinational path from out_ready to in_ready.
  assign in_ready  = (state_q == SWC_FILL);
  assign out_valid = (state_q == SWC_FULL);
  assign dbg_state = state_q;
  assign sample0   = w_q[0];
  assign sample1   = w_q[1];
  assign sample2   = w_q[2];
  assign sample3   = w_q[3];

  assign accept   = in_valid && in_ready && !flush;
  assign fill_inc = (fill_cnt_q == FULL_C) ? FULL_C : fill_cnt_q + 3'd1;
  assign hop_inc  = hop_cnt_q + 3'd1;
  // The first window after reset/flush waits only for the fill; later ones wait for HOP.
  assign emit     = accept && (fill_inc == FULL_C) && (first_q || (hop_inc == HOP_C));

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    fill_cnt_d = fill_cnt_q;
    hop_cnt_d  = hop_cnt_q;
    first_d    = first_q;
    if (flush) begin
      state_d    = SWC_FILL;
      w_d        = '{default: '0};
      fill_cnt_d = '0;
      hop_cnt_d  = '0;
      first_d    = 1'b1;
    end else if (state_q == SWC_FULL) begin
      if (out_ready) state_d = SWC_FILL;
    end else if (accept) begin
      w_d[0]     = w_q[1];
      w_d[1]     = w_q[2];
      w_d[2]     = w_q[3];
      w_d[3]     = mag;
      fill_cnt_d = fill_inc;
      hop_cnt_d  = emit ? 3'd0 : hop_inc;
      if (emit) begin
        state_d = SWC_FULL;
        first_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SWC_FILL;
      w_q        <= '{default: '0};
      fill_cnt_q <= '0;
      hop_cnt_q  <= '0;
      first_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      fill_cnt_q <= fill_cnt_d;
      hop_cnt_q  <= hop_cnt_d;
      first_q    <= first_d;
    end
  end

`ifdef SWC_WINDOW_COUNT_EN
  logic [15:0] win_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
    end else if (flush) begin
      win_cnt_q <= '0;
    end else if (emit) begin
      win_cnt_q <= win_cnt_q + 16'd1;
    end
  end

  assign window_count = win_cnt_q;
`endif

endmodule

// File: tb/tb_sample_window_collector.sv
// Directed bench for sample_window_collector: a HOP=4 instance and a HOP=1 instance.
module tb_sample_window_collector;
  import synth_sample_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  logic out_ready;
  logic signed [23:0] in_sample;
  logic v4, v1;
  logic r4, r1;
  logic ov4, ov1;
  logic [31:0] win4 [4];
  logic [31:0] win1 [4];
  swc_state_t st4, st1;
`ifdef SWC_WINDOW_COUNT_EN
  logic [15:0] wc4, wc1;
`endif

  int tests_run;
  int tests_failed;

  sample_window_collector #(.IN_W(24), .OUT_W(32), .HOP(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_sample (in_sample),
    .in_valid  (v4),
    .in_ready  (r4),
    .sample0   (win4[0]),
    .sample1   (win4[1]),
    .sample2   (win4[2]),
    .sample3   (win4[3]),
    .out_valid (ov4),
    .out_ready (out_ready),
`ifdef SWC_WINDOW_COUNT_EN
    .window_count (wc4),
`endif
    .dbg_state (st4)
  );

  sample_window_collector #(.IN_W(24), .OUT_W(32), .HOP(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_sample (in_sample),
    .in_valid  (v1),
    .in_ready  (r1),
    .sample0   (win1[0]),
    .sample1   (win1[1]),
    .sample2   (win1[2]),
    .sample3   (win1[3]),
    .out_valid (ov1),
    .out_ready (out_ready),
`ifdef SWC_WINDOW_COUNT_EN
    .window_count (wc1),
`endif
    .dbg_state (st1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one sample to the selected instance and hold it until accepted.
  task automatic send(input bit sel, input logic signed [23:0] s);
    int n;
    n = 0;
    in_sample = s;
    if (sel) v1 = 1'b1; else v4 = 1'b1;
    while (!(sel ? r1 : r4) && n < 50) begin
      step();
      n++;
    end
    tests_run++;
    if (n >= 50) begin
      tests_failed++;
      $display("FAIL send_timeout sel=%0d sample=%0d: in_ready stayed 0, required 1", sel, s);
    end
    step();
    v4 = 1'b0;
    v1 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid4 got=%b exp=0", ov4); end
    tests_run++;
    if (r4 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready4 got=%b exp=1", r4); end
    tests_run++;
    if (st4 !== SWC_FILL) begin tests_failed++; $display("FAIL reset_state4 got=%0d exp=%0d", st4, SWC_FILL); end
    tests_run++;
    if (ov1 !== 1'b0 || r1 !== 1'b1) begin
      tests_failed++; $display("FAIL reset_hs1 got ov=%b rdy=%b exp ov=0 rdy=1", ov1, r1);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win4[i] !== 32'd0) begin tests_failed++; $display("FAIL reset_sample%0d got=%h exp=0", i, win4[i]); end
    end
`ifdef SWC_WINDOW_COUNT_EN
    tests_run++;
    if (wc4 !== 16'd0) begin tests_failed++; $display("FAIL reset_window_count got=%0d exp=0", wc4); end
`endif
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_hop4_basic();
    logic [31:0] exp [4];
    exp = '{32'd1, 32'd2, 32'd3, 32'd4};
    out_ready = 1'b1;
    send(0, 24'sd1);
    send(0, -24'sd2);
    send(0, 24'sd3);
    tests_run++;
    if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid got=%b exp=0", ov4); end
    send(0, -24'sd4);
    tests_run++;
    if (ov4 !== 1'b1) begin tests_failed++; $display("FAIL basic_out_valid got=%b exp=1", ov4); end
    tests_run++;
    if (r4 !== 1'b0) begin tests_failed++; $display("FAIL basic_in_ready_low got=%b exp=0", r4); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win4[i] !== exp[i]) begin tests_failed++; $display("FAIL basic_sample%0d got=%0d exp=%0d", i, win4[i], exp[i]); end
    end
`ifdef SWC_WINDOW_COUNT_EN
    tests_run++;
    if (wc4 !== 16'd1) begin tests_failed++; $display("FAIL basic_window_count got=%0d exp=1", wc4); end
`endif
    step();
    tests_run++;
    if (ov4 !== 1'b0 || r4 !== 1'b1) begin
      tests_failed++; $display("FAIL basic_release got ov=%b rdy=%b exp ov=0 rdy=1", ov4, r4);
    end
  endtask

  task automatic test_hop1_sliding();
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    exp_a = '{32'd10, 32'd20, 32'd30, 32'd40};
    exp_b = '{32'd20, 32'd30, 32'd40, 32'd50};
    out_ready = 1'b1;
    send(1, 24'sd10);
    send(1, 24'sd20);
    send(1, 24'sd30);
    tests_run++;
    if (ov1 !== 1'b0) begin tests_failed++; $display("FAIL hop1_early_valid got=%b exp=0", ov1); end
    send(1, 24'sd40);
    tests_run++;
    if (ov1 !== 1'b1) begin tests_failed++; $display("FAIL hop1_first_valid got=%b exp=1", ov1); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win1[i] !== exp_a[i]) begin tests_failed++; $display("FAIL hop1_a_sample%0d got=%0d exp=%0d", i, win1[i], exp_a[i]); end
    end
    step();
    send(1, -24'sd50);
    tests_run++;
    if (ov1 !== 1'b1) begin tests_failed++; $display("FAIL hop1_second_valid got=%b exp=1", ov1); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win1[i] !== exp_b[i]) begin tests_failed++; $display("FAIL hop1_b_sample%0d got=%0d exp=%0d", i, win1[i], exp_b[i]); end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];
    exp_a = '{32'd100, 32'd101, 32'd102, 32'd103};
    exp_b = '{32'd200, 32'd201, 32'd202, 32'd203};
    out_ready = 1'b0;
    send(0, 24'sd100);
    send(0, 24'sd101);
    send(0, 24'sd102);
    send(0, 24'sd103);
    in_sample = 24'sd200;
    v4 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (r4 !== 1'b0 || ov4 !== 1'b1) begin
        tests_failed++; $display("FAIL stall_hs cycle=%0d got rdy=%b ov=%b exp rdy=0 ov=1", c, r4, ov4);
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (win4[i] !== exp_a[i]) begin
          tests_failed++; $display("FAIL stall_sample%0d cycle=%0d got=%0d exp=%0d", i, c, win4[i], exp_a[i]);
        end
      end
      step();
    end
    out_ready = 1'b1;
    send(0, 24'sd200);
    send(0, 24'sd201);
    send(0, 24'sd202);
    tests_run++;
    if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL stall_extra_accept got=%b exp=0", ov4); end
    send(0, 24'sd203);
    tests_run++;
    if (ov4 !== 1'b1) begin tests_failed++; $display("FAIL stall_next_valid got=%b exp=1", ov4); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win4[i] !== exp_b[i]) begin tests_failed++; $display("FAIL stall_next_sample%0d got=%0d exp=%0d", i, win4[i], exp_b[i]); end
    end
    step();
  endtask

  task automatic test_extremes();
    logic [31:0] exp [4];
    exp = '{32'h0080_0000, 32'h007F_FFFF, 32'h0000_0000, 32'h0000_0001};
    out_ready = 1'b1;
    send(0, -24'sd8388608);
    send(0, 24'sd8388607);
    send(0, 24'sd0);
    send(0, -24'sd1);
    tests_run++;
    if (ov4 !== 1'b1) begin tests_failed++; $display("FAIL extreme_valid got=%b exp=1", ov4); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win4[i] !== exp[i]) begin tests_failed++; $display("FAIL extreme_sample%0d got=%h exp=%h", i, win4[i], exp[i]); end
    end
    step();
  endtask

  task automatic test_flush();
    logic [31:0] exp [4];
    exp = '{32'd5, 32'd6, 32'd7, 32'd8};
    out_ready = 1'b1;
    send(0, 24'sd1);
    send(0, 24'sd2);
    flush = 1'b1;
    in_sample = 24'sd77;
    v4 = 1'b1;
    step();
    flush = 1'b0;
    v4 = 1'b0;
    tests_run++;
    if (ov4 !== 1'b0 || r4 !== 1'b1) begin
      tests_failed++; $display("FAIL flush_hs got ov=%b rdy=%b exp ov=0 rdy=1", ov4, r4);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win4[i] !== 32'd0) begin tests_failed++; $display("FAIL flush_clear%0d got=%0d exp=0", i, win4[i]); end
    end
`ifdef SWC_WINDOW_COUNT_EN
    tests_run++;
    if (wc4 !== 16'd0) begin tests_failed++; $display("FAIL flush_window_count got=%0d exp=0", wc4); end
`endif
    send(0, 24'sd5);
    tests_run++;
    if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL flush_early1 got=%b exp=0", ov4); end
    send(0, 24'sd6);
    tests_run++;
    if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL flush_early2 got=%b exp=0", ov4); end
    send(0, -24'sd7);
    tests_run++;
    if (ov4 !== 1'b0) begin tests_failed++; $display("FAIL flush_early3 got=%b exp=0", ov4); end
    send(0, 24'sd8);
    tests_run++;
    if (ov4 !== 1'b1) begin tests_failed++; $display("FAIL flush_window_valid got=%b exp=1", ov4); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win4[i] !== exp[i]) begin tests_failed++; $display("FAIL flush_sample%0d got=%0d exp=%0d", i, win4[i], exp[i]); end
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(0, 24'sd11);
    send(0, 24'sd12);
    send(0, 24'sd13);
    send(0, 24'sd14);
    tests_run++;
    if (ov4 !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_valid got=%b exp=1", ov4); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (ov4 !== 1'b0 || r4 !== 1'b1) begin
      tests_failed++; $display("FAIL areset_hs got ov=%b rdy=%b exp ov=0 rdy=1", ov4, r4);
    end
    tests_run++;
    if (st4 !== SWC_FILL) begin tests_failed++; $display("FAIL areset_state got=%0d exp=%0d", st4, SWC_FILL); end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (win4[i] !== 32'd0) begin tests_failed++; $display("FAIL areset_sample%0d got=%0d exp=0", i, win4[i]); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    out_ready    = 1'b1;
    in_sample    = '0;
    v4           = 1'b0;
    v1           = 1'b0;
    test_reset();
    test_hop4_basic();
    test_hop1_sliding();
    test_backpressure();
    test_extremes();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
